// File: rtl/data_mem_arbiter.sv
// Round-robin two-requester front end for the single-port data memory.
// One request is in flight at a time. It is accepted in IDLE, accesses memory in ISSUE, and responds in RESP.
module data_mem_arbiter #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic              a_write,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_rsp_valid,
  output logic [DATA_W-1:0] a_rsp_rdata,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic              b_write,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_rsp_valid,
  output logic [DATA_W-1:0] b_rsp_rdata,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_writedata,
  output logic              mem_memwrite,
  output logic              mem_memread,
  input  logic [DATA_W-1:0] mem_readdata
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t r_state;
  state_t w_stateNext;

  logic r_lastGrantB;
  logic r_gntB;
  logic r_write;

  logic              w_grantA;
  logic              w_grantB;
  logic              w_accept;
  logic              w_selWrite;
  logic [ADDR_W-1:0] w_selAddr;
  logic [DATA_W-1:0] w_selWdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // On a tie, the requester that did not win last time gets the grant.
  always_comb begin
    w_stateNext = r_state;
    w_grantA    = 1'b0;
    w_grantB    = 1'b0;
    case (r_state)
      IDLE: begin
        if (a_valid && (!b_valid || r_lastGrantB)) begin
          w_grantA = 1'b1;
        end else if (b_valid) begin
          w_grantB = 1'b1;
        end
        if (w_grantA || w_grantB) begin
          w_stateNext = ISSUE;
        end
      end
      ISSUE:   w_stateNext = RESP;
      RESP:    w_stateNext = IDLE;
      default: w_stateNext = IDLE;
    endcase
  end

  assign a_ready    = w_grantA;
  assign b_ready    = w_grantB;
  assign w_accept   = w_grantA | w_grantB;
  assign w_selWrite = w_grantB ? b_write : a_write;
  assign w_selAddr  = w_grantB ? b_addr  : a_addr;
  assign w_selWdata = w_grantB ? b_wdata : a_wdata;

  // Memory controls are loaded at the accept edge, so they are stable for the whole ISSUE cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_lastGrantB  <= 1'b1;
      r_gntB        <= 1'b0;
      r_write       <= 1'b0;
      mem_address   <= '0;
      mem_writedata <= '0;
      mem_memwrite  <= 1'b0;
      mem_memread   <= 1'b0;
      a_rsp_valid   <= 1'b0;
      b_rsp_valid   <= 1'b0;
      a_rsp_rdata   <= '0;
      b_rsp_rdata   <= '0;
    end else begin
      a_rsp_valid <= 1'b0;
      b_rsp_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_gntB        <= w_grantB;
            r_lastGrantB  <= w_grantB;
            r_write       <= w_selWrite;
            mem_address   <= w_selAddr;
            mem_writedata <= w_selWdata;
            mem_memwrite  <= w_selWrite;
            mem_memread   <= ~w_selWrite;
          end
        end
        ISSUE: begin
          mem_memwrite <= 1'b0;
          mem_memread  <= 1'b0;
          if (r_gntB) begin
            b_rsp_valid <= 1'b1;
            if (!r_write) begin
              b_rsp_rdata <= mem_readdata;
            end
          end else begin
            a_rsp_valid <= 1'b1;
            if (!r_write) begin
              a_rsp_rdata <= mem_readdata;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Scoreboarded bench for data_mem_arbiter with a behavioural memory and a transaction-level reference model.
module tb_data_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        a_valid = 1'b0, a_write = 1'b0, b_valid = 1'b0, b_write = 1'b0;
  logic [6:0]  a_addr = '0, b_addr = '0;
  logic [31:0] a_wdata = '0, b_wdata = '0;
  logic        a_ready, b_ready, a_rsp_valid, b_rsp_valid;
  logic [31:0] a_rsp_rdata, b_rsp_rdata;
  logic [6:0]  mem_address;
  logic [31:0] mem_writedata;
  logic [31:0] mem_readdata = '0;
  logic        mem_memwrite, mem_memread;

  typedef struct {
    int          cyc;
    logic        wr;
    logic [6:0]  addr;
    logic [31:0] data;
  } exp_t;

  exp_t        memQ[$];
  exp_t        aQ[$];
  exp_t        bQ[$];
  logic [31:0] envMem[32];
  logic [31:0] refMem[32];
  logic [31:0] expRdA = '0, expRdB = '0;
  int          cyc = 0;
  int          lastAccept = -100;
  bit          lastGrantB = 1'b1;
  logic        rstAtEdge = 1'b0;
  int          aAccCnt = 0, bAccCnt = 0;
  int          nVec = 0, nErr = 0;

  data_mem_arbiter #(.ADDR_W(7), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_ready(a_ready), .a_write(a_write), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_rsp_valid(a_rsp_valid), .a_rsp_rdata(a_rsp_rdata),
    .b_valid(b_valid), .b_ready(b_ready), .b_write(b_write), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_rsp_valid(b_rsp_valid), .b_rsp_rdata(b_rsp_rdata),
    .mem_address(mem_address), .mem_writedata(mem_writedata),
    .mem_memwrite(mem_memwrite), .mem_memread(mem_memread), .mem_readdata(mem_readdata)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nVec++;
    if (act !== exp) begin
      nErr++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // The memory commits writes at posedge and updates its read port at negedge.
  task automatic memWriteSide();
    forever begin
      @(posedge clk);
      rstAtEdge = reset;
      cyc++;
      if (mem_memwrite === 1'b1) envMem[mem_address[6:2]] = mem_writedata;
    end
  endtask

  task automatic memReadSide();
    forever begin
      @(negedge clk);
      mem_readdata = envMem[mem_address[6:2]];
    end
  endtask

  // The reference model is a serialised transaction list: each accept fixes its memory access at +1 and its response at +2.
  task automatic acceptReq(input bit isB, input logic wr, input logic [6:0] addr, input logic [31:0] data);
    exp_t m, r;
    m.cyc = cyc + 1; m.wr = wr; m.addr = addr; m.data = data;
    memQ.push_back(m);
    if (wr) refMem[addr[6:2]] = data;
    else if (isB) expRdB = refMem[addr[6:2]];
    else expRdA = refMem[addr[6:2]];
    r.cyc = cyc + 2; r.wr = wr; r.addr = addr; r.data = isB ? expRdB : expRdA;
    if (isB) begin bQ.push_back(r); bAccCnt++; end
    else begin aQ.push_back(r); aAccCnt++; end
    lastGrantB = isB;
    lastAccept = cyc;
  endtask

  task automatic monitorLoop();
    exp_t e;
    bit   idle, expA, expB;
    forever begin
      @(negedge clk);
      if (rstAtEdge === 1'b1) begin
        checkOutput("rst_mem_address", 32'(mem_address), 32'h0);
        checkOutput("rst_mem_writedata", mem_writedata, 32'h0);
        checkOutput("rst_flags", 32'({mem_memwrite, mem_memread, a_rsp_valid, b_rsp_valid}), 32'h0);
        checkOutput("rst_rsp_rdata", a_rsp_rdata | b_rsp_rdata, 32'h0);
      end
      checkOutput("mem_rw_exclusive", 32'(mem_memwrite & mem_memread), 32'h0);
      if (mem_memwrite === 1'b1 || mem_memread === 1'b1) begin
        if (memQ.size() == 0) checkOutput("mem_unexpected", 32'(memQ.size()), 32'h1);
        else begin
          e = memQ.pop_front();
          checkOutput("mem_cycle", cyc, e.cyc);
          checkOutput("mem_memwrite", 32'(mem_memwrite), 32'(e.wr));
          checkOutput("mem_address", 32'(mem_address), 32'(e.addr));
          if (e.wr) checkOutput("mem_writedata", mem_writedata, e.data);
        end
      end
      if (a_rsp_valid === 1'b1) begin
        if (aQ.size() == 0) checkOutput("a_rsp_unexpected", 32'(aQ.size()), 32'h1);
        else begin
          e = aQ.pop_front();
          checkOutput("a_rsp_cycle", cyc, e.cyc);
          checkOutput("a_rsp_rdata", a_rsp_rdata, e.data);
        end
      end
      if (b_rsp_valid === 1'b1) begin
        if (bQ.size() == 0) checkOutput("b_rsp_unexpected", 32'(bQ.size()), 32'h1);
        else begin
          e = bQ.pop_front();
          checkOutput("b_rsp_cycle", cyc, e.cyc);
          checkOutput("b_rsp_rdata", b_rsp_rdata, e.data);
        end
      end
      while (memQ.size() > 0 && memQ[0].cyc <= cyc) begin
        checkOutput("mem_access_missing", cyc, memQ[0].cyc - 1);
        e = memQ.pop_front();
      end
      while (aQ.size() > 0 && aQ[0].cyc <= cyc) begin
        checkOutput("a_rsp_missing", cyc, aQ[0].cyc - 1);
        e = aQ.pop_front();
      end
      while (bQ.size() > 0 && bQ[0].cyc <= cyc) begin
        checkOutput("b_rsp_missing", cyc, bQ[0].cyc - 1);
        e = bQ.pop_front();
      end
      if (reset === 1'b1) begin
        memQ.delete(); aQ.delete(); bQ.delete();
        lastAccept = -100; lastGrantB = 1'b1; expRdA = '0; expRdB = '0;
      end else begin
        idle = (cyc - lastAccept) >= 3;
        expA = idle && a_valid && (!b_valid || lastGrantB);
        expB = idle && b_valid && !expA;
        checkOutput("ready_pair", 32'({a_ready, b_ready}), 32'({expA, expB}));
        if (a_valid && a_ready === 1'b1) acceptReq(1'b0, a_write, a_addr, a_wdata);
        else if (b_valid && b_ready === 1'b1) acceptReq(1'b1, b_write, b_addr, b_wdata);
      end
    end
  endtask

  // Issues one request and returns once its response cycle has passed.
  task automatic applyStimulus(input bit isB, input logic wr, input logic [6:0] addr, input logic [31:0] data);
    int startCnt = isB ? bAccCnt : aAccCnt;
    bit took = 1'b0;
    if (isB) begin b_valid = 1'b1; b_write = wr; b_addr = addr; b_wdata = data; end
    else begin a_valid = 1'b1; a_write = wr; a_addr = addr; a_wdata = data; end
    for (int i = 0; i < 20 && !took; i++) begin
      @(posedge clk); #1;
      took = (isB ? bAccCnt : aAccCnt) != startCnt;
    end
    checkOutput("req_accepted", 32'(took), 32'h1);
    a_valid = 1'b0; b_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
  endtask

  task automatic runRandom(input int nCycles, input int pct);
    int seenA = aAccCnt, seenB = bAccCnt;
    for (int c = 0; c < nCycles; c++) begin
      if (!a_valid || aAccCnt != seenA) begin
        seenA = aAccCnt;
        a_valid = int'($urandom_range(99)) < pct;
        a_write = 1'($urandom); a_addr = 7'($urandom); a_wdata = $urandom;
      end
      if (!b_valid || bAccCnt != seenB) begin
        seenB = bAccCnt;
        b_valid = int'($urandom_range(99)) < pct;
        b_write = 1'($urandom); b_addr = 7'($urandom); b_wdata = $urandom;
      end
      @(posedge clk); #1;
    end
    a_valid = 1'b0; b_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
  endtask

  task automatic pulseReset();
    a_valid = 1'b0; b_valid = 1'b0; reset = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    reset = 1'b0;
  endtask

  initial begin
    int startCnt;
    for (int i = 0; i < 32; i++) refMem[i] = $urandom;
    refMem[1] = 32'd6;
    refMem[2] = 32'd7;
    for (int i = 0; i < 32; i++) envMem[i] = refMem[i];
    fork
      memWriteSide();
      memReadSide();
      monitorLoop();
    join_none

    repeat (2) begin @(posedge clk); #1; end
    reset = 1'b0;

    applyStimulus(1'b1, 1'b0, 7'h04, 32'h0);
    checkOutput("plan_b_read_word1", b_rsp_rdata, 32'd6);
    checkOutput("plan_a_rdata_untouched", a_rsp_rdata, 32'h0);
    applyStimulus(1'b0, 1'b0, 7'h0B, 32'h0);
    checkOutput("plan_misaligned_read", a_rsp_rdata, 32'd7);
    applyStimulus(1'b0, 1'b1, 7'h08, 32'hDEADBEEF);
    checkOutput("plan_rdata_held_on_write", a_rsp_rdata, 32'd7);
    applyStimulus(1'b0, 1'b0, 7'h08, 32'h0);
    checkOutput("plan_read_back", a_rsp_rdata, 32'hDEADBEEF);
    checkOutput("plan_b_rdata_held", b_rsp_rdata, 32'd6);

    pulseReset();
    runRandom(12, 100);

    startCnt = aAccCnt;
    a_valid = 1'b1; a_write = 1'b0; a_addr = 7'h10;
    for (int i = 0; i < 20 && aAccCnt == startCnt; i++) begin @(posedge clk); #1; end
    checkOutput("midrst_accepted", 32'(aAccCnt != startCnt), 32'h1);
    a_valid = 1'b0; reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    checkOutput("midrst_a_rdata", a_rsp_rdata, 32'h0);
    applyStimulus(1'b0, 1'b0, 7'h08, 32'h0);
    checkOutput("midrst_reissue", a_rsp_rdata, 32'hDEADBEEF);

    runRandom(600, 60);
    runRandom(200, 25);
    repeat (5) begin @(posedge clk); #1; end
    checkOutput("drain_mem_queue", 32'(memQ.size()), 32'h0);
    checkOutput("drain_a_queue", 32'(aQ.size()), 32'h0);
    checkOutput("drain_b_queue", 32'(bQ.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule
